fetch_redirect: RTL and testbench
=================================

# fetch_redirect

Front-end redirect controller sitting directly downstream of the CSR flush logic and the execute-stage branch resolver. It latches a redirect target when `flush` (CSR write, `mret`, exception or interrupt) or a branch redirect is raised. It then holds fetch and drains any outstanding instruction-bus request, discarding that stale response. Finally it hands fetch a single-cycle, registered redirect pulse with the new PC.

## Interface
- `ADDR_W`, 64, PC width.
- `RESET_PC`, `64'h8000_0000`, reset value of the latched target register.

- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: pipeline flush request from the CSR flush logic; 1-cycle pulse.
- `flush_target` in `ADDR_W`: target PC accompanying `flush` (mtvec, mepc or pc+4).
- `br_valid` in 1: execute-stage branch/jump redirect.
- `br_target` in `ADDR_W`: branch target.
- `ireq_busy` in 1: fetch has an ibus request issued whose `data_ok` has not yet returned.
- `iresp_ok` in 1: ibus `data_ok` this cycle.
- `redir_valid` out 1: fetch loads `redir_pc` this cycle.
- `redir_pc` out `ADDR_W`: redirect PC.
- `drop_resp` out 1: fetch must discard the ibus response returning this cycle.
- `fetch_hold` out 1: fetch must not issue a new ibus request this cycle.
- `misalign` out 1: present only under the configuration macro; see Configuration.

## Operation
- Registers:
  - `state` ∈ {IDLE, DRAIN, ISSUE}.
  - `tgt` (`ADDR_W`).
  - `src_is_flush` (1).
- Target capture:
  - `flush` in any state: `tgt ← flush_target`, `src_is_flush ← 1`.
  - `br_valid` accepted only in IDLE and only when `flush=0`: `tgt ← br_target`, `src_is_flush ← 0`.
  - `br_valid` in DRAIN or ISSUE is wrong-path and is ignored.
- IDLE, on an event (`flush|br_valid`):
  - If `ireq_busy & ~iresp_ok`: go to DRAIN.
  - Otherwise: go to ISSUE. If `ireq_busy & iresp_ok`, `drop_resp=1` that cycle.
- DRAIN:
  - `fetch_hold=1`.
  - On `iresp_ok`: `drop_resp=1`, go to ISSUE.
  - A new `flush` only overwrites `tgt`; the state does not change.
- ISSUE:
  - `redir_valid = ~flush`, `redir_pc = tgt`, then go to IDLE.
  - If `flush`, the pulse is suppressed, `tgt` is overwritten and the state stays ISSUE. The fetch bus is idle in ISSUE, so no drain is needed.
- `fetch_hold = (state==DRAIN) | (state==ISSUE & flush) | (state==IDLE & (flush|br_valid))`.
- `drop_resp` is asserted only as stated above; it is never asserted in ISSUE or in IDLE without an event.
- `redir_valid` and `drop_resp` are mutually exclusive within a cycle.

## Timing
- Reset values:
  - `state=IDLE`, `tgt=RESET_PC`, `src_is_flush=0`.
  - `redir_valid=0`, `drop_resp=0`, `fetch_hold=0`, `misalign=0`.
- Reset during DRAIN or ISSUE: return to IDLE next cycle with no pulse and no drop. Fetch handles its own reset.
- Latency, event to `redir_valid`:
  - 1 cycle if no request is outstanding, or if its response arrives in the event cycle.
  - Otherwise the cycle after `iresp_ok`.
- `fetch_hold` is combinational from `flush`/`br_valid`. Fetch must sample it in the same cycle.
- `redir_valid` lasts exactly one cycle per completed redirect. Back-to-back events after the pulse start a new sequence from IDLE.
- No arithmetic other than the optional alignment mask; widths are all `ADDR_W`.

## Configuration
- `FETCH_REDIRECT_ALIGN_CHECK_EN` defined:
  - Port `misalign` exists.
  - On the pulse cycle, `misalign = (tgt[1:0] != 0)`.
  - `redir_pc = {tgt[ADDR_W-1:2], 2'b00}`.
- Not defined:
  - No `misalign` port.
  - `redir_pc = tgt` unmodified.

## Test plan
- IDLE redirect: `flush=1`, `flush_target=0x8000_0100`, `ireq_busy=0` at cycle N -> `fetch_hold=1` at N; `redir_valid=1`, `redir_pc=0x8000_0100` at N+1 only.
- Drain: `flush` at N with `ireq_busy=1`, `iresp_ok` at N+3 -> `fetch_hold=1` N..N+3; `drop_resp=1` at N+3; `redir_valid` at N+4.
- Priority:
  - `flush` (0x8000_0200) and `br_valid` (0x8000_1000) both at N -> `redir_pc=0x8000_0200`.
  - `br_valid` during DRAIN -> ignored.
- Overwrite:
  - `br_valid` 0x8000_1000 at N enters DRAIN; `flush` 0x8000_0300 at N+1 -> pulse carries 0x8000_0300.
  - `flush` arriving in the ISSUE cycle -> pulse suppressed, re-issued next cycle with the new target.
- Reset mid-DRAIN -> IDLE next cycle, all outputs 0, no pulse when `iresp_ok` later arrives.
- With macro: `flush_target=0x8000_0102` -> `redir_pc=0x8000_0100`, `misalign=1` for one cycle. Without macro -> `redir_pc=0x8000_0102`.

Source files
------------

// File: rtl/fetch_redirect_if.sv
// Signal bundle between the redirect controller and its flush/branch/fetch neighbours.
// FETCH_REDIRECT_ALIGN_CHECK_EN adds the misalign flag.
interface fetch_redirect_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              flush;
    logic [ADDR_W-1:0] flush_target;
    logic              br_valid;
    logic [ADDR_W-1:0] br_target;
    logic              ireq_busy;
    logic              iresp_ok;
    logic              redir_valid;
    logic [ADDR_W-1:0] redir_pc;
    logic              drop_resp;
    logic              fetch_hold;
`ifdef FETCH_REDIRECT_ALIGN_CHECK_EN
    logic              misalign;
`endif

    // master: pipeline/fetch side, slave: the redirect controller
    modport master (
        output flush, flush_target, br_valid, br_target, ireq_busy, iresp_ok,
        input  redir_valid, redir_pc, drop_resp, fetch_hold
`ifdef FETCH_REDIRECT_ALIGN_CHECK_EN
        , input misalign
`endif
    );

    modport slave (
        input  flush, flush_target, br_valid, br_target, ireq_busy, iresp_ok,
        output redir_valid, redir_pc, drop_resp, fetch_hold
`ifdef FETCH_REDIRECT_ALIGN_CHECK_EN
        , output misalign
`endif
    );
endinterface

// File: rtl/fetch_redirect.sv
// Front-end redirect controller: latch a flush/branch target, drain the stale ibus response,
// then pulse redir_valid with the new PC. FETCH_REDIRECT_ALIGN_CHECK_EN enables alignment check.
module fetch_redirect #(
    parameter int unsigned            ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]      RESET_PC = 64'h8000_0000
) (
    input logic              clk,
    input logic              reset,
    fetch_redirect_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StDrain, StIssue} state_e;

    state_e            state;
    logic [ADDR_W-1:0] tgt;
    logic              src_is_flush;

    logic              flush;
    logic              br_valid;
    logic              ireq_busy;
    logic              iresp_ok;
    logic              event_in;

    assign flush     = bus.flush;
    assign br_valid  = bus.br_valid;
    assign ireq_busy = bus.ireq_busy;
    assign iresp_ok  = bus.iresp_ok;
    assign event_in  = flush | br_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            tgt          <= RESET_PC;
            src_is_flush <= 1'b0;
        end else begin
            // A branch outside IDLE is on the wrong path; only a flush may retarget then.
            if (flush) begin
                tgt          <= bus.flush_target;
                src_is_flush <= 1'b1;
            end else if (state == StIdle && br_valid) begin
                tgt          <= bus.br_target;
                src_is_flush <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    if (event_in) begin
                        state <= (ireq_busy && !iresp_ok) ? StDrain : StIssue;
                    end
                end
                StDrain: begin
                    if (iresp_ok) begin
                        state <= StIssue;
                    end
                end
                StIssue: begin
                    if (!flush) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.redir_valid = (state == StIssue) && !flush;
    assign bus.fetch_hold  = (state == StDrain) || (state == StIssue && flush) ||
                             (state == StIdle && event_in);
    assign bus.drop_resp   = (state == StIdle && event_in && ireq_busy && iresp_ok) ||
                             (state == StDrain && iresp_ok);

`ifdef FETCH_REDIRECT_ALIGN_CHECK_EN
    assign bus.redir_pc = {tgt[ADDR_W-1:2], 2'b00};
    assign bus.misalign = bus.redir_valid && (tgt[1:0] != 2'b00);
`else
    assign bus.redir_pc = tgt;
`endif

    // A flush always wins target capture, so the source flag must follow it.
    assert property (@(posedge clk) disable iff (reset)
        (!$past(reset) && $past(flush)) |-> src_is_flush);

    assert property (@(posedge clk) disable iff (reset)
        !(bus.redir_valid && bus.drop_resp));
endmodule

// File: tb/tb_fetch_redirect.sv
// Self-checking bench for fetch_redirect: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the redirect sequence.
module tb_fetch_redirect;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    fetch_redirect_if #(.ADDR_W(64)) bus ();

    fetch_redirect #(.ADDR_W(64), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: is a redirect in progress, must it still wait for the stale response, and where to.
    bit          m_pending;
    bit          m_wait_resp;
    logic [63:0] m_tgt;

    // Last sampled DUT outputs.
    logic        o_valid;
    logic        o_drop;
    logic        o_hold;
    logic        o_mis;
    logic [63:0] o_pc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pc_view(input logic [63:0] t);
`ifdef FETCH_REDIRECT_ALIGN_CHECK_EN
        return t & ~64'h3;
`else
        return t;
`endif
    endfunction

    task automatic step(input logic f, input logic [63:0] ft, input logic b,
                        input logic [63:0] bt, input logic busy, input logic ok,
                        input logic rst);
        logic e_valid, e_drop, e_hold, ev;
        @(negedge clk);
        reset            = rst;
        bus.flush        = f;
        bus.flush_target = ft;
        bus.br_valid     = b;
        bus.br_target    = bt;
        bus.ireq_busy    = busy;
        bus.iresp_ok     = ok;
        #1;
        o_valid = bus.redir_valid;
        o_drop  = bus.drop_resp;
        o_hold  = bus.fetch_hold;
        o_pc    = bus.redir_pc;
`ifdef FETCH_REDIRECT_ALIGN_CHECK_EN
        o_mis   = bus.misalign;
`else
        o_mis   = 1'b0;
`endif
        ev = f | b;
        if (!m_pending) begin
            e_valid = 1'b0;
            e_hold  = ev;
            e_drop  = ev & busy & ok;
        end else if (m_wait_resp) begin
            e_valid = 1'b0;
            e_hold  = 1'b1;
            e_drop  = ok;
        end else begin
            e_valid = ~f;
            e_hold  = f;
            e_drop  = 1'b0;
        end
        if (!rst) begin
            chk("redir_valid", {63'd0, o_valid}, {63'd0, e_valid});
            chk("fetch_hold", {63'd0, o_hold}, {63'd0, e_hold});
            chk("drop_resp", {63'd0, o_drop}, {63'd0, e_drop});
            if (e_valid) chk("redir_pc", o_pc, pc_view(m_tgt));
`ifdef FETCH_REDIRECT_ALIGN_CHECK_EN
            chk("misalign", {63'd0, o_mis}, {63'd0, e_valid & (m_tgt[1:0] != 2'b00)});
`endif
        end
        @(posedge clk);
        if (rst) begin
            m_pending   = 1'b0;
            m_wait_resp = 1'b0;
            m_tgt       = RESET_PC;
        end else begin
            if (f) m_tgt = ft;
            else if (!m_pending && b) m_tgt = bt;
            if (!m_pending) begin
                if (ev) begin
                    m_pending   = 1'b1;
                    m_wait_resp = busy & ~ok;
                end
            end else if (m_wait_resp) begin
                if (ok) m_wait_resp = 1'b0;
            end else if (!f) begin
                m_pending = 1'b0;
            end
        end
    endtask

    task automatic idle(input logic busy, input logic ok);
        step(1'b0, 64'd0, 1'b0, 64'd0, busy, ok, 1'b0);
    endtask

    bit          o_req;
    logic        r_f, r_b, r_rst, r_busy, r_ok;
    logic [63:0] r_ft, r_bt;

    initial begin
        total = 0;
        bad   = 0;
        m_pending = 1'b0; m_wait_resp = 1'b0; m_tgt = RESET_PC;
        reset = 1'b1;
        bus.flush = 1'b0; bus.flush_target = '0; bus.br_valid = 1'b0; bus.br_target = '0;
        bus.ireq_busy = 1'b0; bus.iresp_ok = 1'b0;
        step(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);

        // Reset state
        idle(1'b0, 1'b0);
        chk("rst_pc", o_pc, RESET_PC);
        chk("rst_outs", {60'd0, o_valid, o_drop, o_hold, o_mis}, 64'd0);

        // Redirect from IDLE with nothing outstanding
        step(1'b1, 64'h8000_0100, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("idle_hold", {63'd0, o_hold}, 64'd1);
        idle(1'b0, 1'b0);
        chk("idle_pulse", {63'd0, o_valid}, 64'd1);
        chk("idle_pc", o_pc, 64'h8000_0100);
        idle(1'b0, 1'b0);
        chk("idle_once", {63'd0, o_valid}, 64'd0);

        // Drain: response at N+3, pulse at N+4
        step(1'b1, 64'h8000_0180, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        chk("drain_hold", {63'd0, o_hold}, 64'd1);
        idle(1'b1, 1'b1);
        chk("drain_drop", {63'd0, o_drop}, 64'd1);
        idle(1'b0, 1'b0);
        chk("drain_pc", o_pc, 64'h8000_0180);

        // Flush beats a simultaneous branch
        step(1'b1, 64'h8000_0200, 1'b1, 64'h8000_1000, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        chk("prio_pc", o_pc, 64'h8000_0200);

        // Branch during DRAIN is ignored
        step(1'b0, 64'd0, 1'b1, 64'h8000_1000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 64'd0, 1'b1, 64'h8000_2000, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b0);
        chk("br_drain_pc", o_pc, 64'h8000_1000);

        // Flush during DRAIN overwrites the branch target
        step(1'b0, 64'd0, 1'b1, 64'h8000_1000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 64'h8000_0300, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b0);
        chk("ovw_pc", o_pc, 64'h8000_0300);

        // Flush in the ISSUE cycle suppresses and re-issues
        step(1'b1, 64'h8000_0400, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h8000_0500, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("issue_supp", {63'd0, o_valid}, 64'd0);
        idle(1'b0, 1'b0);
        chk("reissue_pc", o_pc, 64'h8000_0500);

        // Reset mid-DRAIN
        step(1'b1, 64'h8000_0600, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
        idle(1'b1, 1'b1);
        chk("rst_drain", {61'd0, o_valid, o_drop, o_hold}, 64'd0);
        idle(1'b0, 1'b0);
        chk("rst_nopulse", {63'd0, o_valid}, 64'd0);

        // Misaligned target
        step(1'b1, 64'h8000_0102, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
`ifdef FETCH_REDIRECT_ALIGN_CHECK_EN
        chk("mis_pc", o_pc, 64'h8000_0100);
        chk("mis_flag", {63'd0, o_mis}, 64'd1);
`else
        chk("mis_pc", o_pc, 64'h8000_0102);
`endif
        idle(1'b0, 1'b0);

        // Random traffic with a simple ibus model: one request in flight at most
        o_req = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r_f    = ($urandom_range(0, 5) == 0);
            r_b    = ($urandom_range(0, 3) == 0);
            r_ft   = {$urandom, $urandom};
            r_bt   = {$urandom, $urandom};
            r_rst  = ($urandom_range(0, 149) == 0);
            r_busy = o_req;
            r_ok   = o_req && ($urandom_range(0, 2) == 0);
            step(r_f, r_ft, r_b, r_bt, r_busy, r_ok, r_rst);
            if (r_rst) begin
                o_req = 1'b0;
            end else begin
                if (r_ok) o_req = 1'b0;
                if (!o_req && !o_hold && $urandom_range(0, 1) == 1) o_req = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
